// File: rtl/game_sched_pkg.sv
// Shared types and constants for the game scheduler: FSM states, menu colours
// and the Konami button-edge sequence used when KONAMI_CODE_EN is defined.
package game_sched_pkg;

    typedef enum logic [1:0] {
        ST_MENU   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_PLAY   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    localparam logic [2:0] COL_BG     = 3'b001;
    localparam logic [2:0] COL_BAND   = 3'b110;
    localparam logic [2:0] COL_SEL    = 3'b100;
    localparam logic [2:0] COL_RESULT = 3'b010;

    // Button edge vectors are packed as {up, down, esc, enter}.
    localparam logic [3:0] BTN_UP    = 4'b1000;
    localparam logic [3:0] BTN_DOWN  = 4'b0100;
    localparam logic [3:0] BTN_ESC   = 4'b0010;
    localparam logic [3:0] BTN_ENTER = 4'b0001;

    localparam logic [2:0] KSTEP_FIRST = 3'd0;
    localparam logic [2:0] KSTEP_LAST  = 3'd5;

    function automatic logic [3:0] konami_expect(input logic [2:0] step);
        case (step)
            3'd0, 3'd1: konami_expect = BTN_UP;
            3'd2, 3'd3: konami_expect = BTN_DOWN;
            3'd4:       konami_expect = BTN_ESC;
            default:    konami_expect = BTN_ENTER;
        endcase
    endfunction

endpackage

// File: rtl/game_scheduler_btn_edge.sv
// Rising-edge detector for one raw button level; rise = level & ~previous level.
module btn_edge (
    input  logic clk,
    input  logic resetn,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!resetn) prev <= 1'b0;
        else         prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/game_scheduler.sv
// Menu/launch/play/result sequencer sharing VGA, buttons and Konami among NGAMES cores.
// Optional Konami code detector in the menu is enabled by defining KONAMI_CODE_EN.
module game_scheduler
    import game_sched_pkg::*;
#(
    parameter int NGAMES       = 3,
    parameter int MENU_Y0      = 40,
    parameter int BAND_H       = 32,
    parameter int RESULT_TICKS = 50000000
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 Up,
    input  logic                 Down,
    input  logic                 Esc,
    input  logic                 Enter,
    input  logic [8:0]           VGAx,
    input  logic [7:0]           VGAy,
    input  logic [3*NGAMES-1:0]  GameCol,
    input  logic [10*NGAMES-1:0] GameScore,
    input  logic [NGAMES-1:0]    GameQuit,
    output logic [NGAMES-1:0]    GameEnable,
    output logic                 GameUp,
    output logic                 GameDown,
    output logic                 GameEsc,
    output logic                 GameEnter,
    output logic                 Konami,
    output logic [2:0]           VGAcol,
    output logic [1:0]           Selected,
    output logic [9:0]           HighScore
);

    localparam int               CNT_W    = $clog2(RESULT_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESULT_TICKS - 1);
    localparam logic [1:0]       SEL_LAST = 2'(NGAMES - 1);

    state_t              state, state_n;
    logic [1:0]          selected, selected_n;
    logic [NGAMES-1:0]   game_enable, enable_n;
    logic                hold_mask, mask_n;
    logic [CNT_W-1:0]    result_cnt, cnt_n;
    logic [9:0]          last_score, last_n;
    logic [9:0]          high_score [NGAMES];
    logic                hs_we;
    logic                up_e, down_e, esc_e, enter_e;
    logic [9:0]          score_sel;
    logic [9:0]          row;
    logic                unused_sink;

    btn_edge u_up    (.clk(Clock), .resetn(Resetn), .level(Up),    .rise(up_e));
    btn_edge u_down  (.clk(Clock), .resetn(Resetn), .level(Down),  .rise(down_e));
    btn_edge u_esc   (.clk(Clock), .resetn(Resetn), .level(Esc),   .rise(esc_e));
    btn_edge u_enter (.clk(Clock), .resetn(Resetn), .level(Enter), .rise(enter_e));

    assign score_sel = GameScore[int'(selected)*10 +: 10];
    assign row       = {2'b00, VGAy};

`ifdef KONAMI_CODE_EN
    logic       konami_r, konami_n;
    logic [2:0] k_step, step_n;
    logic [3:0] edges;
    logic       konami_done;

    assign edges       = {up_e, down_e, esc_e, enter_e};
    assign konami_done = (k_step == KSTEP_LAST) && (edges == BTN_ENTER);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            konami_r <= 1'b0;
            k_step   <= KSTEP_FIRST;
        end else begin
            konami_r <= konami_n;
            k_step   <= step_n;
        end
    end

    // Detector only advances on an edge that is exactly the expected button.
    always_comb begin
        konami_n = konami_r;
        step_n   = k_step;
        if (state == ST_MENU && edges != 4'b0000) begin
            if (edges == konami_expect(k_step)) begin
                if (k_step == KSTEP_LAST) begin
                    konami_n = ~konami_r;
                    step_n   = KSTEP_FIRST;
                end else begin
                    step_n = k_step + 3'd1;
                end
            end else begin
                step_n = up_e ? 3'd1 : KSTEP_FIRST;
            end
        end
        if (state_n != ST_MENU) step_n = KSTEP_FIRST;
    end

    assign Konami = konami_r;
`else
    logic konami_done;
    assign konami_done = 1'b0;
    assign Konami      = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state       <= ST_MENU;
            selected    <= 2'd0;
            game_enable <= '0;
            hold_mask   <= 1'b1;
            result_cnt  <= '0;
            last_score  <= 10'd0;
            for (int i = 0; i < NGAMES; i++) high_score[i] <= 10'd0;
        end else begin
            state       <= state_n;
            selected    <= selected_n;
            game_enable <= enable_n;
            hold_mask   <= mask_n;
            result_cnt  <= cnt_n;
            last_score  <= last_n;
            if (hs_we) high_score[selected] <= score_sel;
        end
    end

    always_comb begin
        state_n    = state;
        selected_n = selected;
        enable_n   = game_enable;
        mask_n     = hold_mask;
        cnt_n      = result_cnt;
        last_n     = last_score;
        hs_we      = 1'b0;
        case (state)
            ST_MENU: begin
                enable_n = '0;
                if (up_e && !down_e)
                    selected_n = (selected == 2'd0) ? SEL_LAST : selected - 2'd1;
                else if (down_e && !up_e)
                    selected_n = (selected == SEL_LAST) ? 2'd0 : selected + 2'd1;
                if (enter_e && !konami_done) state_n = ST_LAUNCH;
            end
            // One idle cycle with every enable low lets the chosen core clear.
            ST_LAUNCH: begin
                enable_n           = '0;
                enable_n[selected] = 1'b1;
                mask_n             = 1'b1;
                state_n            = ST_PLAY;
            end
            ST_PLAY: begin
                if (!(Up || Down || Esc || Enter)) mask_n = 1'b0;
                if (GameQuit[selected]) begin
                    last_n   = score_sel;
                    hs_we    = score_sel > high_score[selected];
                    enable_n = '0;
                    state_n  = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (enter_e || result_cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_MENU;
                end else begin
                    cnt_n = result_cnt + 1'b1;
                end
            end
            default: state_n = ST_MENU;
        endcase
    end

    always_comb begin
        VGAcol = COL_BG;
        case (state)
            ST_PLAY:   VGAcol = GameCol[int'(selected)*3 +: 3];
            ST_RESULT: VGAcol = COL_RESULT;
            ST_MENU: begin
                for (int k = 0; k < NGAMES; k++) begin
                    if (row >= 10'(MENU_Y0 + k*BAND_H) && row < 10'(MENU_Y0 + (k+1)*BAND_H))
                        VGAcol = (2'(k) == selected) ? COL_SEL : COL_BAND;
                end
            end
            default: VGAcol = COL_BG;
        endcase
    end

    assign GameUp      = (state == ST_PLAY) & Up    & ~hold_mask;
    assign GameDown    = (state == ST_PLAY) & Down  & ~hold_mask;
    assign GameEsc     = (state == ST_PLAY) & Esc   & ~hold_mask;
    assign GameEnter   = (state == ST_PLAY) & Enter & ~hold_mask;
    assign GameEnable  = game_enable;
    assign Selected    = selected;
    assign HighScore   = high_score[selected];
    // Column position and the latched final score have no consumer inside this block.
    assign unused_sink = ^{VGAx, last_score, esc_e};

endmodule

// File: doc/game_scheduler.md
Name: game_scheduler

Overview:
- Top-level sequencer that shares the VGA colour path, the four buttons and the Konami flag among NGAMES game cores, such as the Bros core.
- Runs a menu, launches one game at a time, and holds that game's Enable and button inputs.
- Returns to the menu when the active game asserts Quit. Latches that game's final Score and keeps a high score per game.

Parameters:
- NGAMES, 3, number of game cores (2..4).
- MENU_Y0, 40, first VGAy row of the menu bands.
- BAND_H, 32, height of each menu band in rows.
- RESULT_TICKS, 50000000, maximum number of cycles the result screen is shown.

Ports:
- Clock  in  1  system clock.
- Resetn  in  1  synchronous reset, active-low.
- Up, Down, Esc, Enter  in  1 each  raw button levels.
- VGAx  in  9  current pixel column.
- VGAy  in  8  current pixel row.
- GameCol  in  3*NGAMES  per-game pixel colour; game i occupies bits [3i+2:3i].
- GameScore  in  10*NGAMES  per-game Score.
- GameQuit  in  NGAMES  per-game Quit.
- GameEnable  out  NGAMES  one-hot enable; all zero holds every game in reset.
- GameUp, GameDown, GameEsc, GameEnter  out  1 each  gated buttons fanned out to the games.
- Konami  out  1  palette flag to the games.
- VGAcol  out  3  muxed pixel colour.
- Selected  out  2  menu cursor / active game index.
- HighScore  out  10  high score of the Selected game.

Behaviour:
- **States:** MENU, LAUNCH, PLAY, RESULT.
- **Reset** (Resetn=0 at a Clock edge):
  - State = MENU, Selected = 0, GameEnable = 0, all high scores = 0.
  - Konami = 0, hold mask = 1, result counter = 0, LastScore = 0.
- **Button edges:** each button has a registered previous level; edge = level & ~prev. Menu actions use edges only.
- **MENU:**
  - Up edge: Selected decrements, wrapping 0 -> NGAMES-1.
  - Down edge: Selected increments, wrapping NGAMES-1 -> 0.
  - Up and Down edges in the same cycle: no move.
  - Enter edge: go to LAUNCH.
  - Esc is ignored.
  - GameEnable = 0 throughout.
- **LAUNCH:**
  - Lasts exactly 1 cycle, with GameEnable still 0 so the selected game's state clears.
  - Then GameEnable[Selected] = 1 and state = PLAY.
  - Hold mask is set to 1.
- **PLAY:**
  - Game button outputs = raw levels & ~mask. The mask clears in the first cycle where Up, Down, Esc and Enter are all 0, so the launching Enter never reaches the game.
  - Selected is frozen.
  - When GameQuit[Selected] = 1:
    - LastScore <= GameScore[Selected].
    - The high score for Selected is replaced if GameScore[Selected] is strictly greater.
    - GameEnable <= 0 and state = RESULT, all in the same edge.
  - GameQuit of non-selected games is ignored.
- **RESULT:**
  - The counter increments every cycle.
  - Go to MENU when the counter reaches RESULT_TICKS-1 or on an Enter edge, whichever comes first. The counter clears on exit.
  - Game button outputs = 0.
- **VGAcol** (combinational from registered state):
  - PLAY: GameCol[Selected].
  - MENU: a row inside band k (MENU_Y0 + k*BAND_H <= VGAy < MENU_Y0 + (k+1)*BAND_H, k < NGAMES) shows COL_SEL if k == Selected, else COL_BAND. All other rows show COL_BG.
  - LAUNCH: COL_BG.
  - RESULT: COL_RESULT everywhere.
- **HighScore:** combinational read of the high-score entry at Selected.
- **Arithmetic:** high-score comparison is unsigned 10-bit. Selected wrap uses NGAMES, not a power of two.
- **Reset mid-PLAY:** GameEnable drops in the same edge, so the game resets through its Enable input.

Optional Feature:
- **Macro:** KONAMI_CODE_EN.
- **Defined:** in MENU, a sequence detector tracks the button-edge sequence Up, Up, Down, Down, Esc, Enter.
  - Any other edge returns the detector to step 0, or to step 1 if that edge is Up.
  - On completion Konami toggles and state stays MENU; that Enter does not launch.
  - Detector progress clears on leaving MENU. Konami persists until reset.
- **Undefined:** Konami is tied to 0, and Enter in MENU always launches.

Decomposition:
- **Package game_sched_pkg:**
  - State enum.
  - Colour constants COL_BG=3'b001, COL_BAND=3'b110, COL_SEL=3'b100, COL_RESULT=3'b010.
  - Konami sequence step constants.
- **Sub-module btn_edge:** one instance per button. Registers the level and outputs a rise pulse; it is reset by Resetn.

Test Plan:
- Reset, then pulse Down 4 times with NGAMES=3 -> Selected goes 1, 2, 0, 1; GameEnable stays 3'b000.
- Selected=1, Enter edge -> LAUNCH for 1 cycle, then GameEnable=3'b010. GameEnter stays 0 while Enter is held and follows Enter only after a full release.
- In PLAY with GameScore[1]=25, pulse GameQuit[1] -> RESULT, LastScore=25, HighScore=25, GameEnable=0. Replay and quit at score 12 -> HighScore remains 25.
- In RESULT with RESULT_TICKS=100 and no input -> MENU after exactly 100 cycles. A second run with an Enter edge at cycle 10 returns early.
- In MENU with VGAy=75, Selected=1, MENU_Y0=40, BAND_H=32 -> VGAcol=COL_SEL. VGAy=20 -> COL_BG.
- With KONAMI_CODE_EN, press Up Up Down Down Esc Enter -> Konami=1 and no launch. Up Down inserted mid-sequence -> Konami unchanged.
